// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front-end for the TotalALU datapath.
// Takes one ALU command per valid/ready handshake and drives dataA/dataB/Signal.
// Single-cycle ops return one result (tag 0). MULTU is held for MUL_CYCLES,
// then MFHI/MFLO are issued and Hi (tag 1) and Lo (tag 2) are returned in order.
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN. When it is defined, unsupported
// functs are trapped and reported with res_err. When it is undefined, every funct
// is forwarded to the ALU.
module alu_cmd_sequencer #(
   parameter int unsigned MUL_CYCLES = 33,
   parameter logic [5:0]  IDLE_FUNCT = 6'd36
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_funct,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] dataA,
   output logic [31:0] dataB,
   output logic [5:0]  Signal,
   input  logic [31:0] alu_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [1:0]  res_tag,
   output logic        res_err
);

   // ALU function codes this sequencer needs to know by name
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;

   // Last counter value of the multiply hold window
   localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);

   // Result tags seen by the consumer
   localparam logic [1:0] TAG_SINGLE = 2'd0;
   localparam logic [1:0] TAG_HI     = 2'd1;
   localparam logic [1:0] TAG_LO     = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      MUL,
      RDHI,
      RDLO,
      OUT_HI,
      OUT
   } state_t;

   state_t      state;
   logic [5:0]  counter;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        accept;

   assign accept = cmd_valid & cmd_ready;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   // Pending trap: set when an unsupported funct is accepted, consumed in EXEC
   logic trap_q;

   function automatic logic is_supported(input logic [5:0] f);
      case (f)
         6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18: is_supported = 1'b1;
         default:                                                      is_supported = 1'b0;
      endcase
   endfunction

   // Error flag: raised with a trapped result, cleared when that result is taken
   always_ff @(posedge clk) begin
      if (reset) begin
         res_err <= 1'b0;
         trap_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && cmd_funct != F_MULTU && !is_supported(cmd_funct)) begin
                  trap_q <= 1'b1;
               end
            end
            EXEC: begin
               if (trap_q) begin
                  res_err <= 1'b1;
                  trap_q  <= 1'b0;
               end
            end
            OUT: begin
               if (res_ready) begin
                  res_err <= 1'b0;
               end
            end
            default: begin
               res_err <= res_err;
            end
         endcase
      end
   end
`else
   assign res_err = 1'b0;
`endif

   // Main sequencer FSM: handshakes, ALU drive, multiply timing and result staging
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         dataA     <= 32'd0;
         dataB     <= 32'd0;
         Signal    <= IDLE_FUNCT;
         res_valid <= 1'b0;
         res_data  <= 32'd0;
         res_tag   <= TAG_SINGLE;
         counter   <= 6'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cmd_ready <= 1'b0;
                  dataA     <= cmd_a;
                  dataB     <= cmd_b;
                  if (cmd_funct == F_MULTU) begin
                     Signal  <= F_MULTU;
                     counter <= 6'd1;
                     state   <= MUL;
                  end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                  else if (!is_supported(cmd_funct)) begin
                     Signal <= IDLE_FUNCT;
                     state  <= EXEC;
                  end
`endif
                  else begin
                     Signal <= cmd_funct;
                     state  <= EXEC;
                  end
               end
            end

            EXEC: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
               res_data  <= trap_q ? 32'd0 : alu_out;
`else
               res_data  <= alu_out;
`endif
               res_tag   <= TAG_SINGLE;
               res_valid <= 1'b1;
               Signal    <= IDLE_FUNCT;
               state     <= OUT;
            end

            MUL: begin
               if (counter == MUL_LAST) begin
                  Signal <= F_MFHI;
                  state  <= RDHI;
               end else begin
                  counter <= counter + 6'd1;
               end
            end

            RDHI: begin
               hi_q    <= alu_out;
               counter <= 6'd0;
               Signal  <= F_MFLO;
               state   <= RDLO;
            end

            RDLO: begin
               lo_q      <= alu_out;
               res_data  <= hi_q;
               res_tag   <= TAG_HI;
               res_valid <= 1'b1;
               Signal    <= IDLE_FUNCT;
               state     <= OUT_HI;
            end

            OUT_HI: begin
               if (res_ready) begin
                  res_data <= lo_q;
                  res_tag  <= TAG_LO;
                  state    <= OUT;
               end
            end

            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               Signal    <= IDLE_FUNCT;
               res_valid <= 1'b0;
               counter   <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: bench for alu_cmd_sequencer with a behavioural TotalALU.
// The expected results come from plain arithmetic on each command's operands.
// The bench checks latency, the Signal sequence, backpressure hold and reset abort.
// It honours ALU_SEQ_ILLEGAL_TRAP_EN in the same way as the design.
module tb_alu_cmd_sequencer;

   localparam int         MUL_CYCLES = 33;
   localparam logic [5:0] IDLE_FUNCT = 6'd36;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_funct;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  Signal;
   logic [31:0] alu_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [1:0]  res_tag;
   logic        res_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_hi = 32'd0;
   logic [31:0] ref_lo = 32'd0;

   logic [31:0] alu_hi;
   logic [31:0] alu_lo;
   int          mul_run;

   alu_cmd_sequencer #(
      .MUL_CYCLES(MUL_CYCLES),
      .IDLE_FUNCT(IDLE_FUNCT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_funct(cmd_funct),
      .cmd_a    (cmd_a),
      .cmd_b    (cmd_b),
      .dataA    (dataA),
      .dataB    (dataB),
      .Signal   (Signal),
      .alu_out  (alu_out),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .res_tag  (res_tag),
      .res_err  (res_err)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // TotalALU model: combinational result for the function currently on Signal
   always_comb begin
      alu_out = 32'd0;
      case (Signal)
         6'd36:   alu_out = dataA & dataB;
         6'd37:   alu_out = dataA | dataB;
         6'd32:   alu_out = dataA + dataB;
         6'd34:   alu_out = dataA - dataB;
         6'd42:   alu_out = {31'd0, ($signed(dataA) < $signed(dataB))};
         6'd2:    alu_out = dataA >> dataB[4:0];
         6'd16:   alu_out = alu_hi;
         6'd18:   alu_out = alu_lo;
         default: alu_out = 32'd0;
      endcase
   end

   // TotalALU multiplier model: Hi/Lo only update after a full MUL_CYCLES hold of MULTU
   always @(posedge clk) begin
      if (reset) begin
         alu_hi  <= 32'd0;
         alu_lo  <= 32'd0;
         mul_run <= 0;
      end else if (Signal == 6'd25) begin
         if (mul_run == MUL_CYCLES - 1) begin
            {alu_hi, alu_lo} <= {32'd0, dataA} * {32'd0, dataB};
         end
         mul_run <= mul_run + 1;
      end else begin
         mul_run <= 0;
      end
   end

   // Watchdog so the run always ends even if something upstream stalls
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit is_legal(input logic [5:0] f);
      return f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18};
   endfunction

   // Reference result of a single-cycle command from the arithmetic definition of each op
   function automatic logic [31:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         6'd36:   return a & b;
         6'd37:   return a | b;
         6'd32:   return a + b;
         6'd34:   return a - b;
         6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd2:    return a >> b[4:0];
         6'd16:   return ref_hi;
         6'd18:   return ref_lo;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One complete command: handshake, execution checks, then every result with backpressure
   task automatic apply_stimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int stall_min, input int stall_max);
      logic [31:0] exp_data[$];
      logic [1:0]  exp_tag[$];
      logic        exp_err[$];
      logic [5:0]  sig_seen[$];
      logic [63:0] prod;
      int          waited;
      int          moved;
      int          mul_seen;
      int          stall;
      int          held;
      bit          trapped;

      trapped = TRAP && !is_legal(f);
      if (f == 6'd25) begin
         prod = {32'd0, a} * {32'd0, b};
         exp_data.push_back(prod[63:32]); exp_tag.push_back(2'd1); exp_err.push_back(1'b0);
         exp_data.push_back(prod[31:0]);  exp_tag.push_back(2'd2); exp_err.push_back(1'b0);
         ref_hi = prod[63:32];
         ref_lo = prod[31:0];
      end else if (trapped) begin
         exp_data.push_back(32'd0); exp_tag.push_back(2'd0); exp_err.push_back(1'b1);
      end else begin
         exp_data.push_back(ref_op(f, a, b)); exp_tag.push_back(2'd0); exp_err.push_back(1'b0);
      end

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_funct = f;
      cmd_a     = a;
      cmd_b     = b;
      waited    = 0;
      while (cmd_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check_output("cmd_accept", 64'(waited < 100), 64'd1);
      @(negedge clk);

      // Junk on the command port while busy must be ignored
      cmd_funct = 6'($urandom);
      cmd_a     = $urandom;
      cmd_b     = $urandom;

      moved  = 0;
      waited = 0;
      while (res_valid !== 1'b1 && waited < 200) begin
         sig_seen.push_back(Signal);
         if (!trapped && (dataA !== a || dataB !== b)) moved++;
         @(negedge clk);
         waited++;
      end
      cmd_valid = 1'b0;
      check_output("res_timeout", 64'(waited < 200), 64'd1);
      check_output("operands_stable", 64'(moved), 64'd0);

      if (f == 6'd25) begin
         mul_seen = 0;
         foreach (sig_seen[i]) if (sig_seen[i] == 6'd25) mul_seen++;
         check_output("mul_hold_cycles", 64'(mul_seen), 64'(MUL_CYCLES));
         check_output("mul_latency", 64'(sig_seen.size()), 64'(MUL_CYCLES + 2));
         if (sig_seen.size() >= 2) begin
            check_output("mul_read_seq", {sig_seen[sig_seen.size() - 2], sig_seen[sig_seen.size() - 1]},
                         {6'd16, 6'd18});
         end
      end else begin
         check_output("single_latency", 64'(sig_seen.size()), 64'd1);
         if (sig_seen.size() == 1) begin
            check_output("single_signal", sig_seen[0], trapped ? IDLE_FUNCT : f);
         end
      end

      for (int i = 0; i < exp_data.size(); i++) begin
         check_output("res_valid", res_valid, 1'b1);
         check_output("res_data", res_data, exp_data[i]);
         check_output("res_tag", res_tag, exp_tag[i]);
         check_output("res_err", res_err, exp_err[i]);
         check_output("cmd_ready_busy", cmd_ready, 1'b0);
         stall = $urandom_range(stall_max, stall_min);
         held  = 0;
         repeat (stall) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== exp_data[i] || res_tag !== exp_tag[i] ||
                Signal !== IDLE_FUNCT) held++;
         end
         check_output("backpressure_hold", 64'(held), 64'd0);
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
      end
      check_output("res_drained", res_valid, 1'b0);
      check_output("cmd_ready_back", cmd_ready, 1'b1);
      check_output("signal_idle", Signal, IDLE_FUNCT);
   endtask

   // Directed sequence followed by randomized commands
   initial begin
      logic [5:0] legal_f [9];
      int         seen;

      legal_f = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_funct = 6'd0;
      cmd_a     = 32'd0;
      cmd_b     = 32'd0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_cmd_ready", cmd_ready, 1'b1);
      check_output("reset_signal", Signal, IDLE_FUNCT);
      check_output("reset_operands", {dataA, dataB}, 64'd0);
      check_output("reset_res", {res_valid, res_err, res_tag, res_data}, 36'd0);
      reset = 1'b0;

      $display("[TB] directed ADD / SUB / SLT");
      apply_stimulus(6'd32, 32'd7, 32'd5, 0, 0);
      apply_stimulus(6'd34, 32'd3, 32'd5, 0, 0);
      apply_stimulus(6'd42, 32'd3, 32'd5, 0, 0);

      $display("[TB] directed MULTU");
      apply_stimulus(6'd25, 32'hFFFF_FFFF, 32'd2, 0, 0);
      apply_stimulus(6'd16, 32'd0, 32'd0, 0, 0);
      apply_stimulus(6'd25, 32'd65536, 32'd65536, 0, 1);

      $display("[TB] MULTU under backpressure");
      apply_stimulus(6'd25, 32'h1234_5678, 32'h9ABC_DEF0, 20, 20);

      $display("[TB] reset during multiply");
      @(negedge clk);
      check_output("mid_reset_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_funct = 6'd25;
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      check_output("mid_mul_signal", Signal, 6'd25);
      reset = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      ref_hi = 32'd0;
      ref_lo = 32'd0;
      check_output("abort_signal", Signal, IDLE_FUNCT);
      check_output("abort_cmd_ready", cmd_ready, 1'b1);
      check_output("abort_res_valid", res_valid, 1'b0);
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (res_valid !== 1'b0) seen++;
      end
      check_output("abort_no_result", 64'(seen), 64'd0);
      apply_stimulus(6'd32, 32'd1, 32'd1, 0, 0);
      apply_stimulus(6'd16, 32'd0, 32'd0, 0, 0);

      $display("[TB] unsupported funct");
      apply_stimulus(6'd63, 32'd11, 32'd22, 0, 2);

      $display("[TB] randomized commands");
      for (int n = 0; n < 25; n++) begin
         apply_stimulus(legal_f[$urandom_range(8, 0)], $urandom, $urandom, 0, 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
